// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, zero-latency lookup and
// registered training. Define BP_STATS_EN to add branch/mispredict statistic counters.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_addr,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_pred_taken,
    input  logic [31:0] update_pred_addr,
    input  logic        actual_taken,
    input  logic [31:0] actual_target,
    output logic        mispredict,
    output logic [31:0] correct_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       ctr_next;
    logic             unused_pc_bits;

    // Word-aligned PCs: the byte-offset bits carry no information.
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];

    always_comb begin
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = lk_hit && ctr_q[lk_idx][1];
        pred_addr  = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
    end

    // Resolution is suppressed while reset is held so a stale update cannot flush.
    always_comb begin
        mispredict = nRST && update_en &&
                     ((update_pred_taken != actual_taken) ||
                      (actual_taken && (update_pred_addr != actual_target)));
        correct_pc = (update_en && actual_taken) ? actual_target : update_pc + 32'd4;
    end

    always_comb begin
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        ctr_next = ctr_q[up_idx];
        if (actual_taken) begin
            if (ctr_q[up_idx] != 2'b11) ctr_next = ctr_q[up_idx] + 2'b01;
        end else begin
            if (ctr_q[up_idx] != 2'b00) ctr_next = ctr_q[up_idx] - 2'b01;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (update_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next;
                if (actual_taken) target_q[up_idx] <= actual_target;
            end else if (actual_taken) begin
                // Taken miss always allocates, evicting any aliasing branch.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= actual_target;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (update_en && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16); checks stat counters
// too when BP_STATS_EN is defined.
module tb_branch_predictor;

    logic        CLK;
    logic        nRST;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_pred_taken;
    logic [31:0] update_pred_addr;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        mispredict;
    logic [31:0] correct_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .lookup_pc         (lookup_pc),
        .pred_taken        (pred_taken),
        .pred_addr         (pred_addr),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .update_pred_taken (update_pred_taken),
        .update_pred_addr  (update_pred_addr),
        .actual_taken      (actual_taken),
        .actual_target     (actual_target),
        .mispredict        (mispredict),
        .correct_pc        (correct_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic en, input logic [31:0] pc, input logic ptk,
                       input logic [31:0] pa, input logic at, input logic [31:0] tgt);
        update_en         = en;
        update_pc         = pc;
        update_pred_taken = ptk;
        update_pred_addr  = pa;
        actual_taken      = at;
        actual_target     = tgt;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                        input logic [31:0] exp_a);
        lookup_pc = pc;
        #1;
        check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
        check({tag, ".addr"}, pred_addr, exp_a);
    endtask

    task automatic resolve(input string tag, input logic exp_m, input logic [31:0] exp_pc);
        #1;
        check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_m});
        check({tag, ".correct_pc"}, correct_pc, exp_pc);
    endtask

    initial begin
        nRST = 1'b0;
        lookup_pc = 32'h40;
        upd(1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h100);
        #2;
        check("rst_update_ignored", {31'd0, mispredict}, 32'd0);
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #10;
        nRST = 1'b1;
        step();

        look("reset_lookup", 32'h40, 1'b0, 32'h44);
        resolve("reset_idle", 1'b0, 32'h4);
`ifdef BP_STATS_EN
        check("stat_br_init", stat_branches, 32'd0);
        check("stat_mp_init", stat_mispredicts, 32'd0);
`endif

        // Allocation on a taken miss; same-cycle lookup still sees the old (empty) entry.
        upd(1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h100);
        resolve("alloc", 1'b1, 32'h100);
        look("alloc_no_bypass", 32'h40, 1'b0, 32'h44);
        step();
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        look("after_alloc", 32'h40, 1'b1, 32'h100);

        // Four not-taken: 10->01->00->00->00.
        upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        resolve("nt_mispredict", 1'b1, 32'h44);
        step();
        look("nt1", 32'h40, 1'b0, 32'h44);
        upd(1'b1, 32'h40, 1'b0, 32'h44, 1'b0, 32'h0);
        resolve("nt_correct", 1'b0, 32'h44);
        step();
        look("nt2", 32'h40, 1'b0, 32'h44);
        step();
        look("nt3", 32'h40, 1'b0, 32'h44);
        step();
        look("nt4", 32'h40, 1'b0, 32'h44);

        // Taken: 00->01->10->11->11, then NT -> 10 still predicts taken.
        upd(1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h100);
        step();
        look("t1", 32'h40, 1'b0, 32'h44);
        step();
        look("t2", 32'h40, 1'b1, 32'h100);
        upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        resolve("t_correct", 1'b0, 32'h100);
        step();
        step();
        upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        step();
        look("sat_hi_then_nt", 32'h40, 1'b1, 32'h100);
        upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        step();

        // Target change at ctr 11.
        upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h180);
        resolve("target_change", 1'b1, 32'h180);
        step();
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        look("new_target", 32'h40, 1'b1, 32'h180);

        // Aliasing: 0x80 shares index 0 with 0x40.
        upd(1'b1, 32'h80, 1'b0, 32'h84, 1'b1, 32'h200);
        step();
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        look("alias_evicted", 32'h40, 1'b0, 32'h44);
        look("alias_new", 32'h80, 1'b1, 32'h200);
        upd(1'b1, 32'h40, 1'b0, 32'h44, 1'b0, 32'h0);
        step();
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        look("alias_nt_kept", 32'h80, 1'b1, 32'h200);
        look("alias_nt_noalloc", 32'h40, 1'b0, 32'h44);

        // 32-bit wrap of PC+4.
        look("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 32'h0);
        upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        resolve("wrap_correct", 1'b0, 32'h0);

        // Same-cycle lookup/update at one index: old contents visible until the edge.
        upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h300);
        look("same_cycle_old", 32'h80, 1'b1, 32'h200);
        step();
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        look("same_cycle_new", 32'h80, 1'b1, 32'h300);
`ifdef BP_STATS_EN
        check("stat_br_nonzero", {31'd0, (stat_branches != 32'd0)}, 32'd1);
`endif

        // Async reset pulse mid-stream with an update pending.
        upd(1'b1, 32'h40, 1'b0, 32'h44, 1'b1, 32'h500);
        nRST = 1'b0;
        #1;
        check("midrst_mispredict", {31'd0, mispredict}, 32'd0);
        look("midrst_cleared", 32'h80, 1'b0, 32'h84);
        nRST = 1'b1;
        upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        look("post_rst_40", 32'h40, 1'b0, 32'h44);
        look("post_rst_80", 32'h80, 1'b0, 32'h84);
`ifdef BP_STATS_EN
        check("stat_br_rst", stat_branches, 32'd0);
        check("stat_mp_rst", stat_mispredicts, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
